// File: rtl/ysyx_23060187_ifu_pkg.sv
// Shared definitions for the instruction fetch unit, reused by the LSU and the core top.
package ysyx_23060187_ifu_pkg;

  typedef enum logic [2:0] {
    StBoot = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StHold = 3'd3,
    StExec = 3'd4
  } ifu_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInst        = 32'h0000_0013;
  localparam logic [31:0] ResetPcDefault = 32'h8000_0000;
  localparam int unsigned TimeoutDefault = 255;

endpackage

// File: rtl/ysyx_23060187_ifu_timer.sv
// 8-bit wait-cycle counter with clear/enable; flags the cycle in which a wait runs out.
module ysyx_23060187_ifu_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] Last = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the enabled cycle whose increment brings the count to TIMEOUT.
  assign expired = en && (cnt_q == Last);

endmodule

// File: rtl/ysyx_23060187_ifu.sv
// Multi-cycle instruction fetch unit: one outstanding word fetch, decode handshake,
// then waits for writeback to supply the next PC.
module ysyx_23060187_ifu
  import ysyx_23060187_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault,
  parameter int unsigned TIMEOUT  = TimeoutDefault,
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        wbu_valid,
  input  logic [31:0] wbu_next_pc,
  output logic [31:0] pc
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        fault_q, fault_d;
  logic        drop_q, drop_d;
  logic        timer_clr, timer_en, timer_expired;

  ysyx_23060187_ifu_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      fault_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;
    drop_d    = drop_q;
    // A response owed to a timed-out fetch is swallowed whenever it finally shows up.
    if (imem_resp_valid && drop_q) begin
      drop_d = 1'b0;
    end
    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_resp_valid && !drop_q) begin
          inst_d    = imem_resp_err ? NOP_INST : imem_resp_data;
          fault_d   = imem_resp_err;
          inst_pc_d = pc_q;
          state_d   = StHold;
        end else if (timer_expired) begin
          inst_d    = NOP_INST;
          fault_d   = 1'b1;
          inst_pc_d = pc_q;
          drop_d    = 1'b1;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (inst_ready) begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (wbu_valid) begin
          pc_d = wbu_next_pc;
          if (wbu_next_pc[1:0] != 2'b00) begin
            inst_d    = NOP_INST;
            fault_d   = 1'b1;
            inst_pc_d = wbu_next_pc;
            state_d   = StHold;
          end else begin
            state_d = StReq;
          end
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == StReq);
    inst_valid     = (state_q == StHold);
    imem_addr      = pc_q;
    inst           = inst_q;
    inst_pc        = inst_pc_q;
    inst_fault     = fault_q;
    pc             = pc_q;
    timer_clr      = (state_q == StReq) && imem_req_ready;
    timer_en       = (state_q == StWait);
  end

endmodule

// File: doc/ysyx_23060187_ifu.md
Name: ysyx_23060187_ifu

Overview:
Instruction fetch unit feeding the decode/execute datapath of the RV32 core. Owns the architectural PC and issues one word fetch at a time on a valid/ready instruction-memory port. Presents the fetched instruction to decode with a valid/ready handshake, then waits for writeback to return the next PC before fetching again. This replaces the combinational PC-to-memory path with a multi-cycle, latency-tolerant fetch.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 255, WAIT-state cycles without a response before a fetch fault is raised (8-bit counter; must be 1..255).
NOP_INST, 32'h0000_0013, instruction word delivered with any fault (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_addr  out  32  fetch address; equals pc while imem_req_valid is high.
imem_resp_valid  in  1  read data valid; one response per accepted request, in order.
imem_resp_data  in  32  instruction word.
imem_resp_err  in  1  bus error flag, qualified by imem_resp_valid.
inst_valid  out  1  instruction available to decode.
inst_ready  in  1  decode accepts instruction.
inst  out  32  instruction word (NOP_INST on fault).
inst_pc  out  32  PC of inst.
inst_fault  out  1  fetch fault flag accompanying inst.
wbu_valid  in  1  writeback done; next PC valid.
wbu_next_pc  in  32  next PC from the execute/writeback stage.
pc  out  32  current architectural PC.

Behaviour:
- Reset (rst low, asynchronous): state=BOOT, pc=RESET_PC, inst=NOP_INST, inst_pc=RESET_PC, inst_fault=0, timeout counter=0, drop_pending=0. imem_req_valid=0 and inst_valid=0 throughout reset.
- imem_req_valid is (state==REQ); inst_valid is (state==HOLD). Both are decoded from the state register only; no combinational path from any input.
- BOOT -> REQ unconditionally on the first clock after reset release. The first request is visible one cycle after release.
- REQ: hold imem_addr=pc stable until imem_req_ready. On handshake -> WAIT and clear the counter.
- WAIT: counter increments each cycle.
  - imem_resp_valid with drop_pending=1: discard the response, clear drop_pending, stay in WAIT.
  - Otherwise, imem_resp_valid: inst<=resp_data (NOP_INST if resp_err), inst_fault<=resp_err, inst_pc<=pc -> HOLD.
  - Counter reaching TIMEOUT with no response: inst<=NOP_INST, inst_fault<=1, drop_pending<=1 -> HOLD.
  - If the response and the timeout coincide, the response wins.
- HOLD: inst, inst_pc and inst_fault stay stable while inst_valid=1. On inst_ready -> EXEC. Minimum fetch-to-valid latency is 2 cycles after the request handshake (zero-wait memory).
- EXEC: wait for wbu_valid, then pc<=wbu_next_pc.
  - If wbu_next_pc[1:0]!=0: no request is issued; inst<=NOP_INST, inst_fault<=1, inst_pc<=wbu_next_pc -> HOLD.
  - Else -> REQ.
- wbu_valid in any state other than EXEC is ignored. imem_resp_valid in BOOT, REQ, HOLD or EXEC: if drop_pending=1, the response is discarded and drop_pending is cleared; otherwise it is ignored (protocol violation, flagged by a bench assertion).
- pc only changes on reset or on the EXEC wbu_valid event.
- The PC is a plain 32-bit register; wrap at 32'hFFFF_FFFC is the writeback stage's responsibility. The IFU performs no PC arithmetic.

Decomposition:
- Shared package: IFU state encoding (BOOT, REQ, WAIT, HOLD, EXEC; 3 bits), the NOP_INST constant, and the RESET_PC default, so the LSU and the core top reuse them.
- One natural sub-module: ysyx_23060187_ifu_timer. It holds the 8-bit WAIT counter with clear/enable inputs and a timeout output, and also serves the future LSU.

Test Plan:
- Reset release, zero-wait memory returning 32'h0010_0093: addr=32'h8000_0000 at cycle 1; inst_valid at cycle 3 with inst=32'h0010_0093, inst_pc=32'h8000_0000, fault=0.
- imem_req_ready held low 5 cycles: imem_addr stays 32'h8000_0000, no state change; handshake on cycle 6, then normal delivery.
- inst_ready low 4 cycles in HOLD: inst/inst_pc/fault stable. Then wbu_next_pc=32'h8000_0004 gives a next request at 32'h8000_0004.
- imem_resp_err=1 with data 32'hDEAD_BEEF: inst=32'h0000_0013, inst_fault=1, inst_pc=faulting pc.
- No response for 255 WAIT cycles: fault delivered. A late response at 32'h1234_5678 is dropped, and the next fetch returns its own data correctly.
- wbu_next_pc=32'h8000_0102 (misaligned): no imem_req_valid; HOLD with inst_pc=32'h8000_0102, inst_fault=1. Asserting rst mid-WAIT returns pc to 32'h8000_0000 immediately.
